// File: rtl/maze_pkg.sv
// Shared maze geometry, bitmap widths, LFSR polynomial and generator state encoding.
// Imported by the generator, its LFSR and the movement/collision logic.
package maze_pkg;

    localparam int MAZE_COLS         = 10;
    localparam int MAZE_ROWS         = 15;
    localparam int MAZE_FOOD_PER_ROW = 20;

    localparam int H_WALLS_W = (MAZE_ROWS + 1) * MAZE_COLS;
    localparam int V_WALLS_W = MAZE_ROWS * (MAZE_COLS + 1);
    localparam int FOOD_W    = MAZE_ROWS * MAZE_FOOD_PER_ROW;

    // Galois taps for x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] LFSR_MASK         = 32'h8020_0003;
    localparam logic [31:0] MAZE_DEFAULT_SEED = 32'h0000_0001;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_CARVE = 3'd2,
        ST_FOOD  = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
        return cur[0] ? ((cur >> 1) ^ LFSR_MASK) : (cur >> 1);
    endfunction

endpackage

// File: rtl/maze_lfsr.sv
// 32-bit Galois LFSR with load and advance enables; a zero seed is replaced by
// DEFAULT_SEED so the register can never lock up at zero.
module maze_lfsr
    import maze_pkg::*;
#(
    parameter int          TAP_W        = 22,
    parameter logic [31:0] DEFAULT_SEED = MAZE_DEFAULT_SEED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             advance,
    input  logic [31:0]      seed,
    output logic [TAP_W-1:0] taps
);

    logic [31:0] value_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            value_q <= DEFAULT_SEED;
        end else if (load) begin
            value_q <= (seed == 32'd0) ? DEFAULT_SEED : seed;
        end else if (advance) begin
            value_q <= lfsr_next(value_q);
        end
    end

    assign taps = value_q[TAP_W-1:0];

endmodule

// File: rtl/maze_generator.sv
// Binary-tree maze generator: one cell per cycle carve, one food row per cycle.
// Define MAZE_GEN_SHADOW_EN to publish the bitmaps atomically when generation ends.
module maze_generator
    import maze_pkg::*;
#(
    parameter int          COLS         = MAZE_COLS,
    parameter int          ROWS         = MAZE_ROWS,
    parameter int          FOOD_PER_ROW = MAZE_FOOD_PER_ROW,
    parameter logic [31:0] DEFAULT_SEED = MAZE_DEFAULT_SEED
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [31:0]                    seed,
    output logic                           busy,
    output logic                           done,
    output logic [(ROWS+1)*COLS-1:0]       h_walls,
    output logic [ROWS*(COLS+1)-1:0]       v_walls,
    output logic [ROWS*FOOD_PER_ROW-1:0]   food
);

    localparam int HW    = (ROWS + 1) * COLS;
    localparam int VW    = ROWS * (COLS + 1);
    localparam int FW    = ROWS * FOOD_PER_ROW;
    localparam int TAP_W = FOOD_PER_ROW + 2;
    localparam logic [3:0] LAST_COL = 4'(COLS - 1);
    localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);

    state_t state, state_nxt;
    logic [3:0]  row, col, row_nxt, col_nxt;
    logic [HW-1:0] h_q, h_nxt;
    logic [VW-1:0] v_q, v_nxt;
    logic [FW-1:0] food_q, food_nxt;
    logic [TAP_W-1:0] lfsr;
    logic lfsr_load, lfsr_adv;
    logic [8:0] h_idx, v_idx, food_base;
    logic [FOOD_PER_ROW-1:0] food_row;

    maze_lfsr #(
        .TAP_W        (TAP_W),
        .DEFAULT_SEED (DEFAULT_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (lfsr_load),
        .advance (lfsr_adv),
        .seed    (seed),
        .taps    (lfsr)
    );

    assign h_idx     = 9'(row) * 9'(COLS) + 9'(col);
    assign v_idx     = 9'(row) * 9'(COLS + 1) + 9'(col);
    assign food_base = 9'(row) * 9'(FOOD_PER_ROW);

    // A food slot is set when three consecutive LFSR bits are all ones (~1/8 density).
    always_comb begin
        food_row = lfsr[FOOD_PER_ROW-1:0] & lfsr[FOOD_PER_ROW:1] & lfsr[FOOD_PER_ROW+1:2];
        if (row == 4'd0) begin
            food_row[1:0] = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        row_nxt   = row;
        col_nxt   = col;
        h_nxt     = h_q;
        v_nxt     = v_q;
        food_nxt  = food_q;
        lfsr_load = 1'b0;
        lfsr_adv  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    lfsr_load = 1'b1;
                    state_nxt = ST_INIT;
                end
            end
            ST_INIT: begin
                h_nxt     = '1;
                v_nxt     = '1;
                food_nxt  = '0;
                row_nxt   = 4'd0;
                col_nxt   = 4'd0;
                state_nxt = ST_CARVE;
            end
            ST_CARVE: begin
                lfsr_adv = 1'b1;
                // Each cell except (0,0) opens exactly one passage north or west.
                if (row == 4'd0 && col != 4'd0) begin
                    v_nxt = v_q & ~(VW'(1) << v_idx);
                end else if (row != 4'd0 && col == 4'd0) begin
                    h_nxt = h_q & ~(HW'(1) << h_idx);
                end else if (row != 4'd0) begin
                    if (lfsr[0]) begin
                        h_nxt = h_q & ~(HW'(1) << h_idx);
                    end else begin
                        v_nxt = v_q & ~(VW'(1) << v_idx);
                    end
                end
                if (col == LAST_COL) begin
                    col_nxt = 4'd0;
                    if (row == LAST_ROW) begin
                        row_nxt   = 4'd0;
                        state_nxt = ST_FOOD;
                    end else begin
                        row_nxt = row + 4'd1;
                    end
                end else begin
                    col_nxt = col + 4'd1;
                end
            end
            ST_FOOD: begin
                lfsr_adv = 1'b1;
                food_nxt = food_q | (FW'(food_row) << food_base);
                if (row == LAST_ROW) begin
                    row_nxt   = 4'd0;
                    state_nxt = ST_FIN;
                end else begin
                    row_nxt = row + 4'd1;
                end
            end
            ST_FIN: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            row    <= 4'd0;
            col    <= 4'd0;
            h_q    <= '1;
            v_q    <= '1;
            food_q <= '0;
        end else begin
            row    <= row_nxt;
            col    <= col_nxt;
            h_q    <= h_nxt;
            v_q    <= v_nxt;
            food_q <= food_nxt;
        end
    end

    assign busy = (state == ST_INIT) || (state == ST_CARVE) || (state == ST_FOOD);
    assign done = (state == ST_FIN);

`ifdef MAZE_GEN_SHADOW_EN
    logic [HW-1:0] h_out;
    logic [VW-1:0] v_out;
    logic [FW-1:0] food_out;

    // Captured on the last food row so the new maze is visible in the done cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            h_out    <= '1;
            v_out    <= '1;
            food_out <= '0;
        end else if (state == ST_FOOD && row == LAST_ROW) begin
            h_out    <= h_nxt;
            v_out    <= v_nxt;
            food_out <= food_nxt;
        end
    end

    assign h_walls = h_out;
    assign v_walls = v_out;
    assign food    = food_out;
`else
    assign h_walls = h_q;
    assign v_walls = v_q;
    assign food    = food_q;
`endif

endmodule
